// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer register file.
// Contents: FSM state encoding, bus widths, byte-address to word-index helper.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word index of addr relative to base. Addresses below base wrap to a huge
    // index, which the range check then rejects.
    function automatic logic [APB_AW-3:0] word_index(input logic [APB_AW-1:0] addr,
                                                     input logic [APB_AW-1:0] base);
        return (APB_AW-2)'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational address decode for apb_slave_regfile.
// Ports:
//   PADDR  in  byte address of the current setup phase
//   PWRITE in  transfer direction (1 = write)
//   idx    out register index (low 6 bits of the word offset)
//   bad    out transfer must complete with PSLVERR: misaligned, out of range,
//              or a write to the read-only status register (index NUM_REGS-1)
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter int              NUM_REGS  = 8,
    parameter logic [APB_AW-1:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic [APB_AW-1:0] PADDR,
    input  logic              PWRITE,
    output logic [5:0]        idx,
    output logic              bad
);

    logic [APB_AW-3:0] widx;
    logic              range_bad;

    always_comb begin
        widx      = word_index(PADDR, BASE_ADDR);
        idx       = widx[5:0];
        // off >= 4*NUM_REGS is equivalent to floor(off/4) >= NUM_REGS
        range_bad = (widx >= (APB_AW-2)'(NUM_REGS));
        bad       = (PADDR[1:0] != 2'b00) || range_bad ||
                    (PWRITE && (idx == 6'(NUM_REGS - 1)));
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer holding NUM_REGS-1 read/write 32-bit registers plus a
// read-only status word at index NUM_REGS-1, with WAIT_STATES access cycles
// of PREADY low before each completion.
// Ports:
//   PCLK, PRESET              clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE     APB control
//   PADDR, PWDATA             APB address / write data
//   PSTRB                     byte strobes (only with APB_SLV_PSTRB_EN)
//   PRDATA, PREADY, PSLVERR   APB response, all registered
//   status_in                 value returned for the status register
//   wr_pulse, wr_index        one-cycle pulse and index of each committed write
// Build option: define APB_SLV_PSTRB_EN for byte-strobed writes.
//
// state | meaning
// IDLE  | waiting for a setup phase (PSEL=1, PENABLE=0)
// WAIT  | access phase, PREADY low, counting down wait states
// RESP  | PREADY high for one cycle; good writes commit at its end
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 1,
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [APB_DW-1:0] PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  logic [3:0]        PSTRB,
`endif
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [APB_DW-1:0] status_in,
    output logic              wr_pulse,
    output logic [5:0]        wr_index
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t            state;
    logic [3:0]        cnt;
    logic              wr_q;
    logic              bad_q;
    logic [5:0]        idx_q;
    logic [APB_DW-1:0] wdata_q;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]        strb_q;
`endif
    // The status slot is never written; it reads back status_in instead.
    logic [APB_DW-1:0] regs [NUM_REGS];

    logic [5:0]        dec_idx;
    logic              dec_bad;

    logic              rsp_wr;
    logic              rsp_bad;
    logic [5:0]        rsp_idx;
    logic [APB_DW-1:0] rsp_data;
    logic [APB_DW-1:0] wmerge;

    apb_slave_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .PADDR  (PADDR),
        .PWRITE (PWRITE),
        .idx    (dec_idx),
        .bad    (dec_bad)
    );

    // With zero wait states the response is built in the setup cycle itself,
    // before the transfer attributes have been latched.
    always_comb begin
        rsp_wr   = (state == IDLE) ? PWRITE  : wr_q;
        rsp_bad  = (state == IDLE) ? dec_bad : bad_q;
        rsp_idx  = (state == IDLE) ? dec_idx : idx_q;
        rsp_data = '0;
        if (!rsp_wr && !rsp_bad) begin
            if (rsp_idx == 6'(NUM_REGS - 1))
                rsp_data = status_in;
            else
                rsp_data = regs[rsp_idx[IW-1:0]];
        end
    end

    always_comb begin
        wmerge = wdata_q;
`ifdef APB_SLV_PSTRB_EN
        for (int b = 0; b < 4; b++) begin
            if (!strb_q[b])
                wmerge[8*b +: 8] = regs[idx_q[IW-1:0]][8*b +: 8];
        end
`endif
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            bad_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
`ifdef APB_SLV_PSTRB_EN
            strb_q   <= '0;
`endif
            PRDATA   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            wr_pulse <= 1'b0;
            wr_index <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (PSEL && !PENABLE) begin
                        wr_q    <= PWRITE;
                        bad_q   <= dec_bad;
                        idx_q   <= dec_idx;
                        wdata_q <= PWDATA;
`ifdef APB_SLV_PSTRB_EN
                        strb_q  <= PSTRB;
`endif
                        cnt     <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state   <= RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= rsp_bad;
                            PRDATA  <= rsp_data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (PENABLE) begin
                        if (cnt == 4'd1) begin
                            state   <= RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= rsp_bad;
                            PRDATA  <= rsp_data;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (wr_q && !bad_q) begin
                        regs[idx_q[IW-1:0]] <= wmerge;
                        wr_pulse            <= 1'b1;
                        wr_index            <= idx_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile. Three instances share one APB bus and
// differ only in WAIT_STATES (0, 1, 3); each transfer is run against one
// selected instance and only that instance's response is checked.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] status_in = '0;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb = 4'hF;
`endif

    logic [31:0] prdata   [3];
    logic        pready   [3];
    logic        pslverr  [3];
    logic        wr_pulse [3];
    logic [5:0]  wr_index [3];

    int pulses [3] = '{0, 0, 0};
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_regfile #(
            .NUM_REGS    (8),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
            .BASE_ADDR   (32'h0000_1000)
        ) u_dut (
            .PCLK      (clk),
            .PRESET    (rst),
            .PSEL      (psel),
            .PENABLE   (penable),
            .PWRITE    (pwrite),
            .PADDR     (paddr),
            .PWDATA    (pwdata),
`ifdef APB_SLV_PSTRB_EN
            .PSTRB     (pstrb),
`endif
            .PRDATA    (prdata[g]),
            .PREADY    (pready[g]),
            .PSLVERR   (pslverr[g]),
            .status_in (status_in),
            .wr_pulse  (wr_pulse[g]),
            .wr_index  (wr_index[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (wr_pulse[i]) pulses[i]++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata,
                        output logic err, output int acc);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        acc = 1;
        while (!pready[d] && acc < 40) begin
            @(negedge clk);
            acc++;
        end
        rdata = prdata[d];
        err   = pslverr[d];
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        #1;
    endtask

    task automatic do_wr(input string tag, input int d, input logic [31:0] addr,
                         input logic [31:0] data, input logic exp_err, input int exp_acc);
        logic [31:0] rd;
        logic        e;
        int          acc;
        xfer(d, 1'b1, addr, data, rd, e, acc);
        chk({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic do_rd(input string tag, input int d, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_acc);
        logic [31:0] rd;
        logic        e;
        int          acc;
        xfer(d, 1'b0, addr, 32'h0, rd, e, acc);
        chk({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        chk({tag, "_data"}, rd, exp_data);
    endtask

    initial begin
        int p0;
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_pready", 32'(pready[i]), 32'd0);
            chk("rst_prdata", prdata[i], 32'd0);
            chk("rst_pslverr", 32'(pslverr[i]), 32'd0);
            chk("rst_wr_index", 32'(wr_index[i]), 32'd0);
        end
        rst = 1'b0;

        // first write after reset, one wait state
        p = pulses[1];
        do_wr("ws1_wr", 1, 32'h1004, 32'hDEADBEEF, 1'b0, 2);
        chk("ws1_pulse", 32'(pulses[1] - p), 32'd1);
        chk("ws1_wr_index", 32'(wr_index[1]), 32'd1);
        do_rd("ws1_rd", 1, 32'h1004, 32'hDEADBEEF, 1'b0, 2);

        // three wait states: PREADY on the 4th access cycle
        do_wr("ws3_wr", 2, 32'h1000, 32'h0000_00A5, 1'b0, 4);
        do_rd("ws3_rd", 2, 32'h1000, 32'h0000_00A5, 1'b0, 4);

        // zero wait states: PREADY in the first access cycle
        do_wr("ws0_wr", 0, 32'h1008, 32'h1234_5678, 1'b0, 1);
        do_rd("ws0_rd", 0, 32'h1008, 32'h1234_5678, 1'b0, 1);

        // bad accesses
        p = pulses[1];
        do_rd("bad_below", 1, 32'h0FFC, 32'h0, 1'b1, 2);
        do_rd("bad_align", 1, 32'h1002, 32'h0, 1'b1, 2);
        do_wr("bad_range", 1, 32'h1020, 32'h5555_AAAA, 1'b1, 2);
        chk("bad_no_pulse", 32'(pulses[1] - p), 32'd0);
        do_rd("bad_keep", 1, 32'h1004, 32'hDEADBEEF, 1'b0, 2);

        // status register
        status_in = 32'hCAFE0001;
        p = pulses[1];
        do_rd("stat_rd", 1, 32'h101C, 32'hCAFE0001, 1'b0, 2);
        do_wr("stat_wr", 1, 32'h101C, 32'h0000_1234, 1'b1, 2);
        do_rd("stat_rd2", 1, 32'h101C, 32'hCAFE0001, 1'b0, 2);
        chk("stat_no_pulse", 32'(pulses[1] - p), 32'd0);

        // async reset while a write sits in WAIT
        do_wr("pre_wr", 2, 32'h100C, 32'h0BAD_F00D, 1'b0, 4);
        chk("pre_rst_idx", 32'(wr_index[2]), 32'd3);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1008; pwdata = 32'h0000_0077;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_index", 32'(wr_index[2]), 32'd0);
        chk("arst_pready", 32'(pready[2]), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_rd("arst_reg2", 2, 32'h1008, 32'h0, 1'b0, 4);
        do_rd("arst_reg3", 2, 32'h100C, 32'h0, 1'b0, 4);
        p = pulses[2];
        do_wr("arst_wr", 2, 32'h1008, 32'h0000_0055, 1'b0, 4);
        chk("arst_pulse", 32'(pulses[2] - p), 32'd1);
        chk("arst_idx", 32'(wr_index[2]), 32'd2);
        do_rd("arst_rd", 2, 32'h1008, 32'h0000_0055, 1'b0, 4);

`ifdef APB_SLV_PSTRB_EN
        pstrb = 4'hF;
        do_wr("strb_full", 1, 32'h100C, 32'h11223344, 1'b0, 2);
        pstrb = 4'b0101;
        do_wr("strb_part", 1, 32'h100C, 32'hAABBCCDD, 1'b0, 2);
        do_rd("strb_rd", 1, 32'h100C, 32'h11BB33DD, 1'b0, 2);
        pstrb = 4'b0000;
        p = pulses[1];
        do_wr("strb_none", 1, 32'h100C, 32'hFFFFFFFF, 1'b0, 2);
        chk("strb_none_pulse", 32'(pulses[1] - p), 32'd1);
        do_rd("strb_none_rd", 1, 32'h100C, 32'h11BB33DD, 1'b0, 2);
        pstrb = 4'hF;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
